gpio_pad_ctrl: RTL and testbench

//   Pin-side stage of the GPIO peripheral. Takes the gpio_ctrl/gpio_data

---
 rtl/gpio_pad_ctrl.sv | 131 +++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_ctrl.sv
// Pin-side stage of the GPIO peripheral: registered pad output/enable drive,
// synchronised and debounced pad inputs, and per-pin edge interrupts.
module gpio_pad_ctrl #(
   parameter int NUM_IO          = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       reg_ctrl,
   input  logic [31:0]       reg_data,
   input  logic [NUM_IO-1:0] pad_i,
   output logic [NUM_IO-1:0] pad_o,
   output logic [NUM_IO-1:0] pad_oe,
   output logic [NUM_IO-1:0] io_pin_o,
   input  logic [NUM_IO-1:0] irq_en_i,
   input  logic [NUM_IO-1:0] irq_clr_i,
   output logic [NUM_IO-1:0] irq_pend_o,
   output logic              irq_o
);

   logic [NUM_IO-1:0] r_sync [SYNC_STAGES];
   logic [NUM_IO-1:0] w_s;
   logic [NUM_IO-1:0] r_st;
   logic [NUM_IO-1:0] w_accept;
   logic [NUM_IO-1:0] w_oe_nxt;
   logic [NUM_IO-1:0] w_po_nxt;
   logic [NUM_IO-1:0] w_in_mode;
   logic [NUM_IO-1:0] r_pad_o;
   logic [NUM_IO-1:0] r_pad_oe;
   logic [NUM_IO-1:0] r_pend;

   // Mode decode: 01 drives the pad, 10 is input; 00 and 11 leave the pad undriven.
   always_comb begin
      w_oe_nxt  = '0;
      w_po_nxt  = '0;
      w_in_mode = '0;
      for (int i = 0; i < NUM_IO; i++) begin
         w_oe_nxt[i]  = (reg_ctrl[2*i +: 2] == 2'b01);
         w_po_nxt[i]  = (reg_ctrl[2*i +: 2] == 2'b01) & reg_data[i];
         w_in_mode[i] = (reg_ctrl[2*i +: 2] == 2'b10);
      end
   end

   generate
      if (NUM_IO < 16) begin : g_unused
         logic w_unused_bits;
         assign w_unused_bits = ^{reg_ctrl[31:2*NUM_IO], reg_data[31:NUM_IO]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pad_o  <= '0;
         r_pad_oe <= '0;
      end else begin
         r_pad_o  <= w_po_nxt;
         r_pad_oe <= w_oe_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      end else begin
         r_sync[0] <= pad_i;
         for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign w_accept = w_s ^ r_st;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_st <= '0;
            else        r_st <= w_s;
         end
      end else begin : g_debounce
         localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
         logic [CNT_W-1:0] r_cnt [NUM_IO];

         always_comb begin
            w_accept = '0;
            for (int i = 0; i < NUM_IO; i++)
               w_accept[i] = (w_s[i] != r_st[i]) && (r_cnt[i] == LP_LAST);
         end

         // Any cycle where s returns to the stable level restarts the count.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_st <= '0;
               for (int i = 0; i < NUM_IO; i++) r_cnt[i] <= '0;
            end else begin
               for (int i = 0; i < NUM_IO; i++) begin
                  if (w_s[i] == r_st[i]) begin
                     r_cnt[i] <= '0;
                  end else if (w_accept[i]) begin
                     r_st[i]  <= w_s[i];
                     r_cnt[i] <= '0;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                  end
               end
            end
         end
      end
   endgenerate

   // Set has priority so an edge landing with a clear is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
      end else begin
         for (int i = 0; i < NUM_IO; i++) begin
            if (w_accept[i] && w_in_mode[i] && irq_en_i[i]) r_pend[i] <= 1'b1;
            else if (irq_clr_i[i])                            r_pend[i] <= 1'b0;
         end
      end
   end

   assign pad_o      = r_pad_o;
   assign pad_oe     = r_pad_oe;
   assign io_pin_o   = r_st;
   assign irq_pend_o = r_pend;
   assign irq_o      = |r_pend;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: directed scenarios plus random pad/register traffic,
// checked cycle by cycle against a window-based reference model.
module tb_gpio_pad_ctrl;

   localparam int NUM_IO = 2;
   localparam int W      = 9;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [31:0]       reg_ctrl = '0;
   logic [31:0]       reg_data = '0;
   logic [NUM_IO-1:0] pad_i = '0;
   logic [NUM_IO-1:0] irq_en_i = '0;
   logic [NUM_IO-1:0] irq_clr_i = '0;
   logic [NUM_IO-1:0] pad_o;
   logic [NUM_IO-1:0] pad_oe;
   logic [NUM_IO-1:0] io_pin_o;
   logic [NUM_IO-1:0] irq_pend_o;
   logic              irq_o;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];

   gpio_pad_ctrl #(
      .NUM_IO(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .CNT_W(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .reg_ctrl(reg_ctrl), .reg_data(reg_data),
      .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe), .io_pin_o(io_pin_o),
      .irq_en_i(irq_en_i), .irq_clr_i(irq_clr_i),
      .irq_pend_o(irq_pend_o), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   // Reference model: pad samples pass through a two-deep delay, and a level
   // is accepted once the last 16 synchronised samples all disagree with it.
   logic [1:0]  m_sync0, m_sync1, m_st, m_pend;
   logic [15:0] m_win [NUM_IO];

   always @(posedge clk) begin : model
      logic [1:0] e_oe, e_po, mode;
      logic       s_pre, flip;
      e_oe = '0;
      e_po = '0;
      if (!rst_n) begin
         m_sync0 = '0;
         m_sync1 = '0;
         m_st    = '0;
         m_pend  = '0;
         for (int i = 0; i < NUM_IO; i++) m_win[i] = '0;
      end else begin
         for (int i = 0; i < NUM_IO; i++) begin
            s_pre      = m_sync1[i];
            m_sync1[i] = m_sync0[i];
            m_sync0[i] = pad_i[i];
            m_win[i]   = {m_win[i][14:0], s_pre};
            flip       = m_st[i] ? (m_win[i] == 16'h0000) : (m_win[i] == 16'hFFFF);
            mode       = reg_ctrl[2*i +: 2];
            if (flip) m_st[i] = ~m_st[i];
            if (flip && mode == 2'b10 && irq_en_i[i]) m_pend[i] = 1'b1;
            else if (irq_clr_i[i])                    m_pend[i] = 1'b0;
            e_oe[i] = (mode == 2'b01);
            e_po[i] = (mode == 2'b01) & reg_data[i];
         end
      end
      exp_q.push_back({e_po, e_oe, m_st, m_pend, |m_pend});
   end

   always @(negedge clk) begin : monitor
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_pad_o",   32'(pad_o),      32'(e[8:7]));
         check("sb_pad_oe",  32'(pad_oe),     32'(e[6:5]));
         check("sb_io_pin",  32'(io_pin_o),   32'(e[4:3]));
         check("sb_pend",    32'(irq_pend_o), 32'(e[2:1]));
         check("sb_irq",     32'(irq_o),      32'(e[0]));
      end
   end

   task automatic measure(input int pin, input logic lvl, input int want, input string nm);
      int lat;
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (io_pin_o[pin] === lvl) begin
            lat = k;
            break;
         end
      end
      check(nm, 32'(lat), 32'(want));
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all_zero(input string nm);
      check(nm, {23'd0, pad_o, pad_oe, io_pin_o, irq_pend_o, irq_o}, 32'd0);
   endtask

   initial begin : stim
      int hold [NUM_IO];

      // Reset with pads low
      cycles(3);
      check_all_zero("reset_outputs");
      #2 rst_n = 1'b1;

      // Output mode on pin 0
      @(negedge clk);
      reg_ctrl = 32'h1;
      reg_data = 32'h1;
      @(negedge clk);
      check("out_pad_oe0", 32'(pad_oe[0]), 32'd1);
      check("out_pad_o0",  32'(pad_o[0]),  32'd1);

      // Input mode latency both polarities
      reg_ctrl = 32'h2;
      reg_data = 32'h0;
      cycles(3);
      pad_i[0] = 1'b1;
      measure(0, 1'b1, 18, "lat_rise");
      pad_i[0] = 1'b0;
      measure(0, 1'b0, 18, "lat_fall");
      cycles(5);

      // Short glitch must be filtered
      irq_en_i = 2'b01;
      pad_i[0] = 1'b1;
      cycles(10);
      pad_i[0] = 1'b0;
      cycles(30);
      check("glitch_io",  32'(io_pin_o[0]), 32'd0);
      check("glitch_irq", 32'(irq_o),       32'd0);

      // Accepted edge raises interrupt, clear drops it
      pad_i[0] = 1'b1;
      measure(0, 1'b1, 18, "lat_irq_rise");
      check("irq_set_pend", 32'(irq_pend_o[0]), 32'd1);
      check("irq_set_out",  32'(irq_o),         32'd1);
      irq_clr_i = 2'b01;
      @(negedge clk);
      irq_clr_i = 2'b00;
      check("irq_clr_pend", 32'(irq_pend_o[0]), 32'd0);

      // Clear on the same edge as a new accepted edge: set wins
      pad_i[0] = 1'b0;
      cycles(17);
      irq_clr_i = 2'b01;
      @(negedge clk);
      irq_clr_i = 2'b00;
      check("setwins_io",   32'(io_pin_o[0]),   32'd0);
      check("setwins_pend", 32'(irq_pend_o[0]), 32'd1);
      irq_clr_i = 2'b01;
      @(negedge clk);
      irq_clr_i = 2'b00;
      check("setwins_clr", 32'(irq_pend_o[0]), 32'd0);

      // Pin 1 in output mode still feeds back, never interrupts
      reg_ctrl = 32'h4;
      reg_data = 32'h2;
      irq_en_i = 2'b11;
      cycles(2);
      pad_i[1] = 1'b1;
      measure(1, 1'b1, 18, "p1_rise");
      pad_i[1] = 1'b0;
      measure(1, 1'b0, 18, "p1_fall");
      check("p1_pend",   32'(irq_pend_o[1]), 32'd0);
      check("p1_pad_oe", 32'(pad_oe),        32'd2);
      check("p1_pad_o",  32'(pad_o),         32'd2);

      // Reset in the middle of a debounce count
      reg_ctrl = 32'h6;
      cycles(3);
      pad_i[0] = 1'b1;
      cycles(12);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreset_outputs");
      cycles(3);
      #2 rst_n = 1'b1;
      measure(0, 1'b1, 18, "lat_after_reset");
      check("after_reset_pend", 32'(irq_pend_o[0]), 32'd1);

      // Random traffic
      hold[0] = 0;
      hold[1] = 0;
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         for (int i = 0; i < NUM_IO; i++) begin
            if (hold[i] == 0) begin
               pad_i[i] = ~pad_i[i];
               hold[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 40);
            end else begin
               hold[i]--;
            end
         end
         if ($urandom_range(0, 50) == 0) reg_ctrl = 32'($urandom_range(0, 15));
         if ($urandom_range(0, 20) == 0) reg_data = $urandom;
         if ($urandom_range(0, 60) == 0) irq_en_i = 2'($urandom_range(0, 3));
         irq_clr_i = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      irq_clr_i = 2'b00;
      cycles(2);
      #1 check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
